// File: rtl/alu_rx_sequencer_if.sv
// Bus between the byte RX/TX front end, the ALU and the sequencer.
// Handshake: rx_done is a one-cycle strobe with no back-pressure. tx_start is a
// one-cycle request that is raised only while tx_busy=0, and tx_data is stable
// while tx_start=1. ALU outputs alu_c/alu_zero are combinational from alu_a/alu_b/alu_sel.
interface alu_rx_sequencer_if #(
  parameter int bits = 8
);
  logic [7:0]      rx_data;
  logic            rx_done;
  logic            tx_busy;
  logic [bits-1:0] alu_c;
  logic            alu_zero;
  logic [bits-1:0] alu_a;
  logic [bits-1:0] alu_b;
  logic [3:0]      alu_sel;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            busy;
  logic            overrun;
  logic            timeout;
  logic [2:0]      dbg_state;

  modport slave (
    input  rx_data, rx_done, tx_busy, alu_c, alu_zero,
    output alu_a, alu_b, alu_sel, tx_data, tx_start, busy, overrun, timeout, dbg_state
  );

  modport master (
    output rx_data, rx_done, tx_busy, alu_c, alu_zero,
    input  alu_a, alu_b, alu_sel, tx_data, tx_start, busy, overrun, timeout, dbg_state
  );
endinterface

// File: rtl/alu_rx_sequencer.sv
// Collects A, B and opcode bytes, runs them through the external ALU and
// returns the result byte followed by a flags byte {7'b0, zero}.
module alu_rx_sequencer #(
  parameter int bits    = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_rx_sequencer_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_WAIT_A   = 3'd0;
  localparam logic [2:0] S_WAIT_B   = 3'd1;
  localparam logic [2:0] S_WAIT_OP  = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_SEND_RES = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_SEND_FLG = 3'd6;
  localparam logic [2:0] S_WAIT_FLG = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [bits-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]      sel_q, sel_d;
  logic [bits-1:0] result_q, result_d;
  logic            zflag_q, zflag_d;
  logic [7:0]      txd_q, txd_d;
  logic            txs_q, txs_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic            seen_q, seen_d;
  logic            in_frame, expire;

  assign in_frame = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
  // A byte arriving on the expiry cycle rescues the frame.
  assign expire   = in_frame && (timer_q == TLAST) && !bus.rx_done;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    zflag_d  = zflag_q;
    txd_d    = txd_q;
    txs_d    = 1'b0;
    wcnt_d   = wcnt_q;
    seen_d   = seen_q;
    case (state_q)
      S_WAIT_A: begin
        timer_d = '0;
        if (bus.rx_done) begin
          a_d     = bus.rx_data;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B, S_WAIT_OP: begin
        if (bus.rx_done) begin
          timer_d = '0;
          if (state_q == S_WAIT_B) begin
            b_d     = bus.rx_data;
            state_d = S_WAIT_OP;
          end else begin
            sel_d   = bus.rx_data[3:0];
            state_d = S_EXEC;
          end
        end else if (expire) begin
          timer_d = '0;
          state_d = S_WAIT_A;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EXEC: begin
        result_d = bus.alu_c;
        zflag_d  = bus.alu_zero;
        state_d  = S_SEND_RES;
      end
      S_SEND_RES, S_SEND_FLG: begin
        if (!bus.tx_busy) begin
          txs_d   = 1'b1;
          txd_d   = (state_q == S_SEND_RES) ? result_q[7:0] : {7'b0, zflag_q};
          wcnt_d  = 2'd0;
          seen_d  = 1'b0;
          state_d = (state_q == S_SEND_RES) ? S_WAIT_RES : S_WAIT_FLG;
        end
      end
      default: begin
        // WAIT_RES / WAIT_FLG: busy must rise then fall, or never rise within 2 cycles.
        if (bus.tx_busy) begin
          seen_d = 1'b1;
        end else if (seen_q || (wcnt_q == 2'd2)) begin
          state_d = (state_q == S_WAIT_RES) ? S_SEND_FLG : S_WAIT_A;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_WAIT_A;
      timer_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      zflag_q  <= 1'b0;
      txd_q    <= '0;
      txs_q    <= 1'b0;
      wcnt_q   <= '0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
      txd_q    <= txd_d;
      txs_q    <= txs_d;
      wcnt_q   <= wcnt_d;
      seen_q   <= seen_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.tx_data   = txd_q;
  assign bus.tx_start  = txs_q;
  assign bus.busy      = (state_q != S_WAIT_A);
  assign bus.overrun   = bus.rx_done && (state_q != S_WAIT_A) && !in_frame;
  assign bus.timeout   = expire;
  assign bus.dbg_state = state_q;
endmodule
